// File: rtl/uc_pkg.sv
// Shared encodings for the pine16 microcode sequencer: sequencing ops,
// flag selects, FSM states and default widths.
package uc_pkg;

  localparam int UPC_W_DEF   = 8;
  localparam int OPC_W_DEF   = 9;
  localparam int STACK_D_DEF = 4;

  // Sequencing field of the current microinstruction.
  typedef enum logic [2:0] {
    SEQ_NEXT     = 3'd0,
    SEQ_JUMP     = 3'd1,
    SEQ_BRANCH   = 3'd2,
    SEQ_CALL     = 3'd3,
    SEQ_RET      = 3'd4,
    SEQ_DISPATCH = 3'd5,
    SEQ_HALT     = 3'd6,
    SEQ_RSVD     = 3'd7
  } seq_op_e;

  // Flag select; the index matches the bit position in flags = {V,C,N,Z}.
  typedef enum logic [1:0] {
    COND_Z = 2'd0,
    COND_N = 2'd1,
    COND_C = 2'd2,
    COND_V = 2'd3
  } cond_sel_e;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DISP_WAIT = 2'd1,
    ST_HALT      = 2'd2
  } state_e;

  // Branch condition: the selected flag, optionally inverted.
  function automatic logic cond_eval(input logic [3:0] flags,
                                     input logic [1:0] sel,
                                     input logic       inv);
    return flags[sel] ^ inv;
  endfunction

endpackage

// File: rtl/uc_stack.sv
// Micro-call return-address stack (LIFO). The pointer counts valid entries;
// push on full and pop on empty are ignored here and reported by the caller.
module uc_stack #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(D + 1);
  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]     mem [D];
  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] sp_m1;
  logic [IDX_W-1:0] idx_push;
  logic [IDX_W-1:0] idx_top;

  assign sp_m1    = sp - PTR_W'(1);
  assign idx_push = sp[IDX_W-1:0];
  assign idx_top  = sp_m1[IDX_W-1:0];
  assign full     = (sp == PTR_W'(D));
  assign empty    = (sp == '0);
  assign top      = mem[idx_top];

  // Stack pointer: entry count, cleared by reset.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + PTR_W'(1);
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

  // Entry storage written on a successful push.
  // NOTE: storage is deliberately not reset; an entry is only read after it was pushed.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[idx_push] <= push_data;
    end
  end

endmodule

// File: rtl/uc_sequencer.sv
// pine16 microcode sequencer: produces the micro-PC for the control store and
// selects the next one from sequential, jump, branch, call/return, or opcode
// dispatch through a synchronous jump ROM (address issued combinationally in
// the DISPATCH cycle, data consumed in DISP_WAIT).
module uc_sequencer
  import uc_pkg::*;
#(
  parameter int               UPC_W     = UPC_W_DEF,
  parameter int               OPC_W     = OPC_W_DEF,
  parameter int               STACK_D   = STACK_D_DEF,
  parameter logic [UPC_W-1:0] RESET_UPC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [2:0]       seq_op,
  input  logic [UPC_W-1:0] seq_target,
  input  logic [1:0]       cond_sel,
  input  logic             cond_inv,
  input  logic [3:0]       flags,
  input  logic [OPC_W-1:0] ir_opcode,
  input  logic             ir_valid,
  output logic             ir_ack,
  output logic [OPC_W-1:0] jrom_addr,
  input  logic [UPC_W-1:0] jrom_data,
  output logic [UPC_W-1:0] upc,
  output logic             halted,
  output logic             stack_err
);

  state_e           state_q, state_d;
  logic [UPC_W-1:0] upc_q, upc_d;
  logic [UPC_W-1:0] upc_inc;
  logic [OPC_W-1:0] jaddr_q;
  logic             err_q, err_set;
  logic             push, pop;
  logic [UPC_W-1:0] stk_top;
  logic             stk_full, stk_empty;
  seq_op_e          op;

  assign op      = seq_op_e'(seq_op);
  assign upc_inc = upc_q + UPC_W'(1);

  uc_stack #(
    .W (UPC_W),
    .D (STACK_D)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (upc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Next-state, next-upc and stack/handshake controls; stall freezes everything.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    ir_ack  = 1'b0;
    if (!stall) begin
      case (state_q)
        ST_RUN: begin
          case (op)
            SEQ_JUMP:   upc_d = seq_target;
            SEQ_BRANCH: upc_d = cond_eval(flags, cond_sel, cond_inv) ? seq_target : upc_inc;
            SEQ_CALL: begin
              if (stk_full) begin
                err_set = 1'b1;
                state_d = ST_HALT;
              end else begin
                push  = 1'b1;
                upc_d = seq_target;
              end
            end
            SEQ_RET: begin
              if (stk_empty) begin
                err_set = 1'b1;
                state_d = ST_HALT;
              end else begin
                pop   = 1'b1;
                upc_d = stk_top;
              end
            end
            SEQ_DISPATCH: begin
              if (ir_valid) begin
                ir_ack  = 1'b1;
                state_d = ST_DISP_WAIT;
              end
            end
            SEQ_HALT: state_d = ST_HALT;
            default:  upc_d = upc_inc;  // NEXT and the reserved encoding
          endcase
        end
        ST_DISP_WAIT: begin
          upc_d   = jrom_data;
          state_d = ST_RUN;
        end
        default: ;  // HALT: frozen until reset
      endcase
    end
  end

  // The ROM samples the opcode in the issue cycle; afterwards the latched
  // address keeps the ROM output valid through any stall in DISP_WAIT.
  assign jrom_addr = ir_ack ? ir_opcode : jaddr_q;

  // Sequencer state, micro-PC, latched ROM address and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      upc_q   <= RESET_UPC;
      jaddr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      if (ir_ack) begin
        jaddr_q <= ir_opcode;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign upc       = upc_q;
  assign halted    = (state_q == ST_HALT);
  assign stack_err = err_q;

endmodule

// File: tb/tb_uc_sequencer.sv
// Directed bench for uc_sequencer with a behavioural 512x8 synchronous jump ROM.
module tb_uc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic [2:0] seq_op;
  logic [7:0] seq_target;
  logic [1:0] cond_sel;
  logic       cond_inv;
  logic [3:0] flags;
  logic [8:0] ir_opcode;
  logic       ir_valid;
  logic       ir_ack;
  logic [8:0] jrom_addr;
  logic [7:0] jrom_data;
  logic [7:0] upc;
  logic       halted;
  logic       stack_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] rom [512];

  localparam logic [2:0] OP_NEXT = 3'd0, OP_JUMP = 3'd1, OP_BRANCH = 3'd2,
                         OP_CALL = 3'd3, OP_RET = 3'd4, OP_DISP = 3'd5, OP_HALT = 3'd6;

  uc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .seq_op     (seq_op),
    .seq_target (seq_target),
    .cond_sel   (cond_sel),
    .cond_inv   (cond_inv),
    .flags      (flags),
    .ir_opcode  (ir_opcode),
    .ir_valid   (ir_valid),
    .ir_ack     (ir_ack),
    .jrom_addr  (jrom_addr),
    .jrom_data  (jrom_data),
    .upc        (upc),
    .halted     (halted),
    .stack_err  (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read jump ROM, one cycle of latency.
  always @(posedge clk) jrom_data <= rom[jrom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] tgt);
    seq_op     = op;
    seq_target = tgt;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    stall     = 1'b0;
    ir_valid  = 1'b0;
    ir_opcode = '0;
    flags     = '0;
    cond_sel  = 2'd0;
    cond_inv  = 1'b0;
    drive(OP_NEXT, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(OP_NEXT, 8'h00);
    #2;
    total++; if (upc !== 8'h00) begin bad++; $display("FAIL reset_upc got=%h exp=00", upc); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
    total++; if (stack_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", stack_err); end
    total++; if (ir_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ir_ack); end
    total++; if (jrom_addr !== 9'h000) begin bad++; $display("FAIL reset_jaddr got=%h exp=000", jrom_addr); end
    apply_reset();
  endtask

  task automatic test_next_wrap();
    logic [7:0] exp_upc;
    drive(OP_NEXT, 8'h00);
    for (int i = 0; i < 300; i++) begin
      step();
      exp_upc = 8'((i + 1) % 256);
      total++;
      if (upc !== exp_upc) begin
        bad++;
        $display("FAIL next_wrap[%0d] got=%h exp=%h", i, upc, exp_upc);
      end
    end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL next_halted got=%b exp=0", halted); end
    // Reserved encoding behaves as NEXT.
    drive(3'd7, 8'h99); step();
    total++; if (upc !== 8'h2D) begin bad++; $display("FAIL rsvd_next got=%h exp=2d", upc); end
  endtask

  task automatic test_branch();
    drive(OP_JUMP, 8'h30); step();
    total++; if (upc !== 8'h30) begin bad++; $display("FAIL jump got=%h exp=30", upc); end
    drive(OP_BRANCH, 8'h40);
    cond_sel = 2'd0; cond_inv = 1'b0; flags = 4'b0001; step();
    total++; if (upc !== 8'h40) begin bad++; $display("FAIL br_z_taken got=%h exp=40", upc); end
    flags = 4'b0000; step();
    total++; if (upc !== 8'h41) begin bad++; $display("FAIL br_z_not got=%h exp=41", upc); end
    cond_inv = 1'b1; step();
    total++; if (upc !== 8'h40) begin bad++; $display("FAIL br_z_inv got=%h exp=40", upc); end
    cond_sel = 2'd2; flags = 4'b0100; step();
    total++; if (upc !== 8'h41) begin bad++; $display("FAIL br_c_inv got=%h exp=41", upc); end
    cond_sel = 2'd3; cond_inv = 1'b0; flags = 4'b1000; drive(OP_BRANCH, 8'h77); step();
    total++; if (upc !== 8'h77) begin bad++; $display("FAIL br_v got=%h exp=77", upc); end
    cond_sel = 2'd1; flags = 4'b1101; step();
    total++; if (upc !== 8'h78) begin bad++; $display("FAIL br_n_not got=%h exp=78", upc); end
    cond_inv = 1'b0; flags = 4'b0000;
  endtask

  task automatic test_dispatch();
    drive(OP_JUMP, 8'h08); step();
    drive(OP_DISP, 8'h00); ir_opcode = 9'h123; ir_valid = 1'b0;
    #1;
    total++; if (ir_ack !== 1'b0) begin bad++; $display("FAIL disp_noack got=%b exp=0", ir_ack); end
    step();
    total++; if (upc !== 8'h08) begin bad++; $display("FAIL disp_hold got=%h exp=08", upc); end
    ir_valid = 1'b1;
    #1;
    total++; if (ir_ack !== 1'b1) begin bad++; $display("FAIL disp_ack got=%b exp=1", ir_ack); end
    total++; if (jrom_addr !== 9'h123) begin bad++; $display("FAIL disp_addr got=%h exp=123", jrom_addr); end
    step();
    drive(OP_NEXT, 8'h00); ir_valid = 1'b0; ir_opcode = 9'h000;
    #1;
    total++; if (upc !== 8'h08) begin bad++; $display("FAIL disp_wait_upc got=%h exp=08", upc); end
    total++; if (ir_ack !== 1'b0) begin bad++; $display("FAIL disp_ack_pulse got=%b exp=0", ir_ack); end
    total++; if (jrom_addr !== 9'h123) begin bad++; $display("FAIL disp_addr_hold got=%h exp=123", jrom_addr); end
    step();
    total++; if (upc !== 8'h5A) begin bad++; $display("FAIL disp_target got=%h exp=5a", upc); end
  endtask

  task automatic test_call_ret();
    drive(OP_JUMP, 8'h05); step();
    drive(OP_CALL, 8'h10); step();
    total++; if (upc !== 8'h10) begin bad++; $display("FAIL call1 got=%h exp=10", upc); end
    drive(OP_CALL, 8'h20); step();
    total++; if (upc !== 8'h20) begin bad++; $display("FAIL call2 got=%h exp=20", upc); end
    drive(OP_RET, 8'hEE); step();
    total++; if (upc !== 8'h11) begin bad++; $display("FAIL ret1 got=%h exp=11", upc); end
    step();
    total++; if (upc !== 8'h06) begin bad++; $display("FAIL ret2 got=%h exp=06", upc); end
    total++; if (stack_err !== 1'b0) begin bad++; $display("FAIL callret_err got=%b exp=0", stack_err); end
  endtask

  task automatic test_stall_dispatch();
    // Stall in RUN holds upc.
    stall = 1'b1; drive(OP_NEXT, 8'h00); step();
    total++; if (upc !== 8'h06) begin bad++; $display("FAIL stall_run got=%h exp=06", upc); end
    stall = 1'b0;
    drive(OP_DISP, 8'h00); ir_opcode = 9'h0AB; ir_valid = 1'b1; step();
    ir_valid = 1'b0; ir_opcode = 9'h1FF; drive(OP_JUMP, 8'hCC); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (upc !== 8'h06) begin bad++; $display("FAIL stall_dw_upc[%0d] got=%h exp=06", i, upc); end
      total++; if (jrom_addr !== 9'h0AB) begin bad++; $display("FAIL stall_dw_addr[%0d] got=%h exp=0ab", i, jrom_addr); end
    end
    stall = 1'b0; step();
    total++; if (upc !== 8'h77) begin bad++; $display("FAIL stall_dw_target got=%h exp=77", upc); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(OP_CALL, 8'(i * 16)); step();
      total++; if (upc !== 8'(i * 16)) begin bad++; $display("FAIL nest_call[%0d] got=%h exp=%h", i, upc, 8'(i * 16)); end
    end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL nest_halted got=%b exp=0", halted); end
    drive(OP_CALL, 8'hF0); step();
    total++; if (stack_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", stack_err); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL ovf_halted got=%b exp=1", halted); end
    total++; if (upc !== 8'h40) begin bad++; $display("FAIL ovf_upc got=%h exp=40", upc); end
    drive(OP_RET, 8'h00); step();
    total++; if (upc !== 8'h40) begin bad++; $display("FAIL halt_frozen got=%h exp=40", upc); end
    apply_reset();
    drive(OP_RET, 8'h00); step();
    total++; if (stack_err !== 1'b1) begin bad++; $display("FAIL unf_err got=%b exp=1", stack_err); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL unf_halted got=%b exp=1", halted); end
    total++; if (upc !== 8'h00) begin bad++; $display("FAIL unf_upc got=%h exp=00", upc); end
  endtask

  task automatic test_halt_op();
    apply_reset();
    drive(OP_NEXT, 8'h00); step();
    drive(OP_HALT, 8'h00); step();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL haltop got=%b exp=1", halted); end
    total++; if (stack_err !== 1'b0) begin bad++; $display("FAIL haltop_err got=%b exp=0", stack_err); end
    drive(OP_JUMP, 8'h55); step();
    total++; if (upc !== 8'h01) begin bad++; $display("FAIL haltop_upc got=%h exp=01", upc); end
  endtask

  task automatic test_reset_mid_dispatch();
    apply_reset();
    drive(OP_JUMP, 8'h33); step();
    drive(OP_DISP, 8'h00); ir_opcode = 9'h123; ir_valid = 1'b1; step();
    drive(OP_NEXT, 8'h00); ir_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (upc !== 8'h00) begin bad++; $display("FAIL rst_mid_upc got=%h exp=00", upc); end
    total++; if (jrom_addr !== 9'h000) begin bad++; $display("FAIL rst_mid_addr got=%h exp=000", jrom_addr); end
    #2;
    rst_n = 1'b1;
    step();
    total++; if (upc !== 8'h01) begin bad++; $display("FAIL rst_mid_run got=%h exp=01", upc); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 8'(i) ^ 8'hA5;
    rom[9'h123] = 8'h5A;
    rom[9'h0AB] = 8'h77;
    rst_n = 1'b0; stall = 1'b0; ir_valid = 1'b0; ir_opcode = '0;
    flags = '0; cond_sel = '0; cond_inv = 1'b0; seq_op = '0; seq_target = '0;
    test_reset();
    test_next_wrap();
    test_branch();
    test_dispatch();
    test_call_ret();
    test_stall_dispatch();
    test_overflow();
    test_halt_op();
    test_reset_mid_dispatch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
